// File: rtl/cond_eval_unit.sv
`default_nettype none
// ============================================================================
// cond_eval_unit : NZCV status register, per-lane ARM condition evaluation,
//                  and predicated-run (IT-style) condition override sequencer.
// Revision       : 1.0
// ============================================================================
module cond_eval_unit #(
  parameter int LANES     = 2,
  parameter int IT_MAX    = 4,
  parameter bit SR_BYPASS = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        sr_wr_en,
  input  logic [3:0]                  sr_wr_data,
  input  logic [3:0]                  sr_wr_mask,
  input  logic [LANES-1:0]            lane_valid,
  input  logic [4*LANES-1:0]          lane_cond,
  input  logic                        it_start,
  input  logic [3:0]                  it_cond,
  input  logic [$clog2(IT_MAX+1)-1:0] it_len,
  input  logic [IT_MAX-1:0]           it_mask,
  output logic [LANES-1:0]            check_valid,
  output logic [LANES-1:0]            check,
  output logic [3:0]                  sr_q,
  output logic                        it_active,
  output logic [$clog2(IT_MAX+1)-1:0] it_remaining
);

  localparam int            LW        = $clog2(IT_MAX + 1);
  localparam logic [LW-1:0] C_IT_MAX  = LW'(IT_MAX);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_ACTIVE = 1'b1;

  logic [3:0]             r_sr;
  logic [LANES-1:0]       r_check_valid;
  logic [LANES-1:0]       r_check;
  logic [0:0]             r_state;
  logic [LW-1:0]          r_it_rem;
  logic [LW-1:0]          r_it_len;
  logic [3:0]             r_it_cond;
  logic [IT_MAX-1:0]      r_it_mask;

  logic [3:0]             w_sr_merge;
  logic [3:0]             w_flags;
  logic [LANES-1:0][3:0]  w_eff_cond;
  logic [LANES-1:0]       w_pass;
  logic [LW-1:0]          w_consumed;
  logic [LW-1:0]          w_len_clamp;
  logic [LW-1:0]          w_rem_nxt;
  logic                   w_run_load;
  logic [0:0]             w_state_nxt;

  function automatic logic f_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'd0:    f_eval = z;
      4'd1:    f_eval = !z;
      4'd2:    f_eval = c;
      4'd3:    f_eval = !c;
      4'd4:    f_eval = n;
      4'd5:    f_eval = !n;
      4'd6:    f_eval = v;
      4'd7:    f_eval = !v;
      4'd8:    f_eval = c & !z;
      4'd9:    f_eval = !c | z;
      4'd10:   f_eval = (n == v);
      4'd11:   f_eval = (n != v);
      4'd12:   f_eval = !z & (n == v);
      4'd13:   f_eval = z | (n != v);
      4'd14:   f_eval = 1'b1;
      default: f_eval = 1'b0;
    endcase
  endfunction

  assign w_sr_merge = (r_sr & ~sr_wr_mask) | (sr_wr_data & sr_wr_mask);

  generate
    if (SR_BYPASS) begin : g_flags_bypass
      assign w_flags = sr_wr_en ? w_sr_merge : r_sr;
    end else begin : g_flags_reg
      assign w_flags = r_sr;
    end
  endgenerate

  // Valid lanes claim run slots in ascending lane order until the run is used up.
  always_comb begin
    int                j;
    int                s;
    logic [IT_MAX-1:0] sh;
    j  = 0;
    s  = 0;
    sh = '0;
    w_eff_cond = '0;
    w_pass     = '0;
    for (int i = 0; i < LANES; i++) begin
      w_eff_cond[i] = lane_cond[4*i +: 4];
      if (lane_valid[i] && (j < int'(r_it_rem))) begin
        s  = int'(r_it_len) - int'(r_it_rem) + j;
        sh = r_it_mask >> s;
        w_eff_cond[i] = sh[0] ? r_it_cond : (r_it_cond ^ 4'b0001);
        j  = j + 1;
      end
      w_pass[i] = lane_valid[i] & f_eval(w_eff_cond[i], w_flags);
    end
    w_consumed = LW'(j);
  end

  always_comb begin
    w_run_load  = it_start && (it_len != '0);
    w_len_clamp = (it_len > C_IT_MAX) ? C_IT_MAX : it_len;
    // A new run discards whatever the old run consumed this cycle.
    w_rem_nxt   = w_run_load ? w_len_clamp : (r_it_rem - w_consumed);
    w_state_nxt = (w_rem_nxt != '0) ? ST_ACTIVE : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_check_valid <= '0;
      r_check       <= '0;
      r_state       <= ST_IDLE;
      r_it_rem      <= '0;
      r_it_len      <= '0;
      r_it_cond     <= '0;
      r_it_mask     <= '0;
    end else if (!stall) begin
      r_state       <= w_state_nxt;
      r_it_rem      <= w_rem_nxt;
      r_check_valid <= lane_valid;
      r_check       <= w_pass;
      if (sr_wr_en) begin
        r_sr <= w_sr_merge;
      end
      if (w_run_load) begin
        r_it_len  <= w_len_clamp;
        r_it_cond <= it_cond;
        r_it_mask <= it_mask;
      end
    end
  end

  always_comb begin
    it_active    = (r_state == ST_ACTIVE);
    it_remaining = r_it_rem;
    sr_q         = r_sr;
    check_valid  = r_check_valid;
    check        = r_check;
  end

endmodule
`default_nettype wire
